// File: rtl/rom_stream_writer.sv
// Packs the ROM loader byte stream into little-endian 16-bit words and writes them to SDRAM
// over a req/ack toggle handshake. Define ROM_CHECKSUM_EN to add the checksum_o output.
module rom_stream_writer #(
  parameter int ADDR_W     = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              wclk_i,
  input  logic              reset_i,
  input  logic [7:0]        din_i,
  input  logic              din_valid_i,
  input  logic              loading_i,
  output logic              mem_req_o,
  input  logic              mem_ack_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_din_o,
  output logic [1:0]        mem_ds_o,
  output logic              done_o,
  output logic              overflow_o,
`ifdef ROM_CHECKSUM_EN
  output logic [15:0]       checksum_o,
`endif
  output logic [23:0]       bytes_written_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // state | meaning
  // IDLE  | no write outstanding; issue the FIFO head when one is available
  // WAIT  | write issued, holding addr/data/ds until mem_ack matches mem_req
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic              loading_q;
  logic              phase_q, phase_d;
  logic [7:0]        lo_q, lo_d;
  logic              flush_q, flush_d;
  logic              fell_q, fell_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [23:0]       bw_q, bw_d;
  logic [0:0]        state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [1:0]        ds_q, ds_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [17:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef ROM_CHECKSUM_EN
  logic [15:0]       cks_q, cks_d;
`endif

  logic        rise, fall, accept, push_req, push_ok, drop, issue, empty, full;
  logic [17:0] push_word;

  assign rise      = loading_i & ~loading_q;
  assign fall      = ~loading_i & loading_q;
  assign accept    = din_valid_i & loading_i;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_req  = flush_q | (accept & phase_q);
  assign push_word = flush_q ? {8'h00, lo_q, 2'b01} : {din_i, lo_q, 2'b11};
  // The head leaves the FIFO when issued, so a full FIFO can accept a push in that same cycle.
  assign issue     = (state_q == ST_IDLE) & ~empty & (req_q == mem_ack_i);
  assign push_ok   = push_req & (~full | issue);
  assign drop      = push_req & full & ~issue;

  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    flush_d = 1'b0;
    fell_d  = fell_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    bw_d    = bw_q;
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ds_d    = ds_q;
    word_d  = word_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
`ifdef ROM_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    if (rise) begin
      phase_d = 1'b0;
      lo_d    = 8'h00;
      fell_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      bw_d    = '0;
      state_d = ST_IDLE;
      addr_d  = '0;
      din_d   = '0;
      ds_d    = 2'b11;
      word_d  = '0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
`ifdef ROM_CHECKSUM_EN
      cks_d   = '0;
`endif
    end else begin
      if (fall) begin
        fell_d  = 1'b1;
        flush_d = phase_q;
      end
      if (flush_q) begin
        phase_d = 1'b0;
      end else if (accept) begin
        bw_d    = bw_q + 24'd1;
`ifdef ROM_CHECKSUM_EN
        cks_d   = cks_q + {8'h00, din_i};
`endif
        phase_d = ~phase_q;
        if (!phase_q) lo_d = din_i;
      end
      if (drop) ovf_d = 1'b1;
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      if (issue) rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(issue);

      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            addr_d       = word_q;
            {din_d, ds_d} = fifo_q[rd_q];
            req_d        = ~req_q;
            state_d      = ST_WAIT;
          end
        end
        default: begin
          if (mem_ack_i == req_q) begin
            word_d  = word_q + ADDR_W'(1);
            state_d = ST_IDLE;
          end
        end
      endcase

      done_d = ~loading_i & fell_q & ~phase_q & ~flush_q & empty & (state_q == ST_IDLE);
    end
  end

  always_ff @(posedge wclk_i) begin
    if (reset_i) begin
      loading_q <= 1'b0;
      phase_q   <= 1'b0;
      lo_q      <= 8'h00;
      flush_q   <= 1'b0;
      fell_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bw_q      <= '0;
      state_q   <= ST_IDLE;
      req_q     <= mem_ack_i;
      addr_q    <= '0;
      din_q     <= '0;
      ds_q      <= 2'b11;
      word_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
`ifdef ROM_CHECKSUM_EN
      cks_q     <= '0;
`endif
    end else begin
      loading_q <= loading_i;
      phase_q   <= phase_d;
      lo_q      <= lo_d;
      flush_q   <= flush_d;
      fell_q    <= fell_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      bw_q      <= bw_d;
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      ds_q      <= ds_d;
      word_q    <= word_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
`ifdef ROM_CHECKSUM_EN
      cks_q     <= cks_d;
`endif
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge wclk_i) begin
    if (push_ok && !rise) fifo_q[wr_q] <= push_word;
  end

  assign mem_req_o       = req_q;
  assign mem_addr_o      = addr_q;
  assign mem_din_o       = din_q;
  assign mem_ds_o        = ds_q;
  assign done_o          = done_q;
  assign overflow_o      = ovf_q;
  assign bytes_written_o = bw_q;
`ifdef ROM_CHECKSUM_EN
  assign checksum_o      = cks_q;
`endif

endmodule
